compressor_sched: RTL and testbench
===================================

# compressor_sched

Time-shares one compressor lookup-table read port among `N_CH` signed 12-bit audio channels. Each channel posts a sample with a strobe. The block picks pending channels round-robin and issues one sign-folded table address per clock, pipelined. When the table result returns, it restores the sign and writes a 16-bit compressed sample into that channel's output register. It sits between the per-chip sound sources (AY, SAA, GS, covox) and the mixer, and owns the single table port so the mixer only ever sees finished samples.

## Interface
- `N_CH`, 4: number of channels, 2..8.
- `TBL_LAT`, 1: clocks from `tbl_addr` being sampled to the matching `tbl_q` being valid, 1..3.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  N_CH*12  channel samples, two's complement; channel c is bits [12c+11:12c].
- `in_stb`  in  N_CH  one-cycle strobe per channel: sample valid.
- `tbl_addr`  out  11  registered table address.
- `tbl_q`  in  15  table data, valid `TBL_LAT` clocks after the address.
- `out_data`  out  N_CH*16  compressed samples, held between updates; channel c is bits [16c+15:16c].
- `out_stb`  out  N_CH  one-cycle pulse when that channel's `out_data` updates.
- `ovr`  out  N_CH  sticky overrun flag per channel.
- `ovr_clr`  in  1  clears all `ovr` bits.

## Operation
- **Sample capture:** `in_stb[c]` latches `in_data[c]` into the channel's sample register and sets `pend[c]`.
- **Grant:**
  - At most one channel is granted per clock, chosen round-robin starting at the channel after the last grant.
  - A grant clears `pend[c]`.
  - It registers `tbl_addr = {11{s[11]}} ^ s[10:0]`.
  - It pushes {valid, channel index, sign} into a `TBL_LAT`-deep tag pipe.
- **Result write:** when a valid tag exits the pipe, the block registers `out_data[ch] = {sign, {15{sign}} ^ tbl_q}` and pulses `out_stb[ch]`.
- **No pending channels:** `tbl_addr` holds its value and the pipe shifts in invalid tags.
- **Strobe on the granted channel, same cycle:**
  - The grant uses the old sample.
  - The new sample is latched and `pend` stays set.
  - This is not an overrun.
- **Overrun:**
  - Trigger: `in_stb[c]` arrives while `pend[c]` is set and c is not granted that cycle.
  - The sample is overwritten (newest wins) and `ovr[c]` is set.
  - `ovr[c]` stays set until `ovr_clr`.
  - `ovr_clr` and a new overrun in the same cycle: the overrun wins.
- **Wrap-around:** the round-robin pointer wraps from N_CH-1 to 0.
- **Grant-state machine:** IDLE (no pend) ↔ GRANT (at least one pend). There is no stall state; the table port never back-pressures.

## Timing
- **Reset values:**
  - `out_data` = 0, `out_stb` = 0, `tbl_addr` = 0, `ovr` = 0.
  - `pend` = 0, tag pipe invalid, round-robin pointer = 0.
- **Reset mid-operation:** in-flight tags are discarded and no `out_stb` is produced for them.
- **Best-case latency:**
  - Edge E0 samples `in_stb`.
  - Grant at E1.
  - Result written at E(1+TBL_LAT+1).
  - `out_stb` is high for the cycle after that edge.
  - With TBL_LAT=1 this is 3 clocks.
- **Worst case:** with all channels pending, a channel waits at most N_CH-1 extra clocks.
- **Throughput:** one sample per clock.

## Configuration
- Macro: `COMPRESSOR_SCHED_BYPASS_EN`.
- **When defined:**
  - Adds port `bypass  in  N_CH`.
  - A channel with `bypass[c]`=1 still flows through the same grant and pipe slot, so latency is unchanged.
  - For such a channel, the written value is `{s, 4'b0}` (linear, ignoring `tbl_q`).
  - Its `bypass` bit is sampled at grant time and carried in the tag.
- **When undefined:** the port and the tag bit are absent, and every channel is compressed.

## Structure
- **Package `compressor_pkg`:**
  - Constants SAMPLE_W=12, ADDR_W=11, Q_W=15, OUT_W=16.
  - Functions `fold_addr(sample)` and `unfold(sign, q)`.
  - Tag struct typedef {valid, ch, sign[, bypass]}.
- **Sub-module `rr_arbiter`:**
  - Parameter N.
  - Inputs: request vector and grant-enable.
  - Outputs: one-hot grant and index.
  - Owns the pointer register.

## Test plan
Table model returns `q = addr<<4`, TBL_LAT=1.
- Strobe ch0 with 0x100 → `tbl_addr`=0x100 after E1; `out_data[0]`=0x1000 and `out_stb[0]` one cycle, 3 clocks after the strobe.
- Strobe ch1 with 0xF00 → `tbl_addr`=0x0FF; `out_data[1]`=0xF00F.
- Strobe ch1 with 0x800 → `tbl_addr`=0x7FF; `out_data[1]`=0x800F.
- Strobe all 4 channels in one cycle → grants on consecutive clocks in order 0,1,2,3; then strobe all again → order 0,1,2,3 (pointer wrapped).
- Strobe ch2 twice while blocked behind ch0/ch1 → only the second value emerges; `ovr[2]`=1 until `ovr_clr`; `ovr_clr` in the same cycle as a new overrun → `ovr` stays 1.
- Assert reset with a tag in flight → no `out_stb`, all outputs 0; the next strobe after release follows normal 3-clock latency.

Source files
------------

// File: rtl/compressor_pkg.sv
// Shared constants, tag format and sign fold/unfold helpers for the compressor scheduler.
package compressor_pkg;

   localparam int SAMPLE_W = 12;
   localparam int ADDR_W   = 11;
   localparam int Q_W      = 15;
   localparam int OUT_W    = 16;
   localparam int CH_W     = 3;

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_e;

   typedef struct packed {
      logic            valid;
      logic [CH_W-1:0] ch;
      logic            sign;
`ifdef COMPRESSOR_SCHED_BYPASS_EN
      logic            bypass;
`endif
   } tag_t;

   // Negative samples index the table by magnitude-ish folding so one half-table serves both signs.
   function automatic logic [ADDR_W-1:0] fold_addr(input logic [SAMPLE_W-1:0] sample);
      return {ADDR_W{sample[SAMPLE_W-1]}} ^ sample[ADDR_W-1:0];
   endfunction

   function automatic logic [OUT_W-1:0] unfold(input logic sign, input logic [Q_W-1:0] q);
      return {sign, {Q_W{sign}} ^ q};
   endfunction

endpackage

// File: rtl/compressor_sched_rr_arbiter.sv
// Round-robin arbiter: searches from the channel after the last grant, one grant per clock.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req_i,
   input  logic             gnt_en_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             vld_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   int               c;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      c     = 0;
      ptr_d = ptr_q;
      if (gnt_en_i) begin
         for (int k = 0; k < N; k++) begin
            c = int'(ptr_q) + k;
            if (c >= N) c = c - N;
            if (!vld_o && req_i[c]) begin
               vld_o    = 1'b1;
               gnt_o[c] = 1'b1;
               idx_o    = IDX_W'(c);
            end
         end
      end
      if (vld_o) ptr_d = (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/compressor_sched.sv
// Shares one compressor table read port among N_CH channels, round-robin, one lookup per clock.
// Optional COMPRESSOR_SCHED_BYPASS_EN adds a per-channel linear bypass carried through the same pipe slot.
module compressor_sched
   import compressor_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int TBL_LAT = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_CH*SAMPLE_W-1:0] in_data,
   input  logic [N_CH-1:0]          in_stb,
`ifdef COMPRESSOR_SCHED_BYPASS_EN
   input  logic [N_CH-1:0]          bypass,
`endif
   output logic [ADDR_W-1:0]        tbl_addr,
   input  logic [Q_W-1:0]           tbl_q,
   output logic [N_CH*OUT_W-1:0]    out_data,
   output logic [N_CH-1:0]          out_stb,
   output logic [N_CH-1:0]          ovr,
   input  logic                     ovr_clr
);

   localparam int IDX_W = $clog2(N_CH);

   logic [SAMPLE_W-1:0]   samp_q [N_CH];
   logic [SAMPLE_W-1:0]   samp_d [N_CH];
   logic [N_CH-1:0]       pend_q, pend_d, ovr_q, ovr_d, out_stb_q, out_stb_d;
   logic [ADDR_W-1:0]     tbl_addr_q, tbl_addr_d;
   logic [N_CH*OUT_W-1:0] out_data_q, out_data_d;
   state_e                state_q, state_d;
   tag_t                  tag_q [TBL_LAT+1];
   tag_t                  tag_in, tag_out;
   logic [N_CH-1:0]       gnt;
   logic [IDX_W-1:0]      gnt_idx;
   logic                  gnt_vld, gnt_en;
   logic [SAMPLE_W-1:0]   gnt_samp;
   logic [OUT_W-1:0]      res;
`ifdef COMPRESSOR_SCHED_BYPASS_EN
   logic [ADDR_W-1:0]     baddr_q [TBL_LAT];
`endif

   rr_arbiter #(.N(N_CH)) u_arb (
      .clk      (clk),
      .reset    (reset),
      .req_i    (pend_q),
      .gnt_en_i (gnt_en),
      .gnt_o    (gnt),
      .idx_o    (gnt_idx),
      .vld_o    (gnt_vld)
   );

   always_comb begin
      state_d = state_q;
      gnt_en  = 1'b0;
      unique case (state_q)
         ST_IDLE:  if (|pend_d) state_d = ST_GRANT;
         ST_GRANT: begin
            gnt_en = 1'b1;
            if (~|pend_d) state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // A strobe on the channel being granted this cycle re-arms pend and is not an overrun.
   always_comb begin
      samp_d   = samp_q;
      pend_d   = pend_q & ~gnt;
      ovr_d    = ovr_clr ? '0 : ovr_q;
      gnt_samp = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (gnt[c]) gnt_samp = samp_q[c];
         if (in_stb[c]) begin
            samp_d[c] = in_data[c*SAMPLE_W +: SAMPLE_W];
            pend_d[c] = 1'b1;
            if (pend_q[c] && !gnt[c]) ovr_d[c] = 1'b1;
         end
      end
      tbl_addr_d   = gnt_vld ? fold_addr(gnt_samp) : tbl_addr_q;
      tag_in       = '0;
      tag_in.valid = gnt_vld;
      tag_in.ch    = CH_W'(gnt_idx);
      tag_in.sign  = gnt_samp[SAMPLE_W-1];
`ifdef COMPRESSOR_SCHED_BYPASS_EN
      tag_in.bypass = |(bypass & gnt);
`endif
   end

   always_comb begin
      tag_out = tag_q[TBL_LAT];
      res     = unfold(tag_out.sign, tbl_q);
`ifdef COMPRESSOR_SCHED_BYPASS_EN
      if (tag_out.bypass)
         res = {tag_out.sign, {ADDR_W{tag_out.sign}} ^ baddr_q[TBL_LAT-1], 4'b0};
`endif
      out_data_d = out_data_q;
      out_stb_d  = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (tag_out.valid && int'(tag_out.ch) == c) begin
            out_data_d[c*OUT_W +: OUT_W] = res;
            out_stb_d[c]                 = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < N_CH; c++) samp_q[c] <= '0;
         for (int i = 0; i <= TBL_LAT; i++) tag_q[i] <= '0;
         pend_q     <= '0;
         ovr_q      <= '0;
         tbl_addr_q <= '0;
         out_data_q <= '0;
         out_stb_q  <= '0;
         state_q    <= ST_IDLE;
      end else begin
         samp_q     <= samp_d;
         pend_q     <= pend_d;
         ovr_q      <= ovr_d;
         tbl_addr_q <= tbl_addr_d;
         out_data_q <= out_data_d;
         out_stb_q  <= out_stb_d;
         state_q    <= state_d;
         tag_q[0]   <= tag_in;
         for (int i = 1; i <= TBL_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

`ifdef COMPRESSOR_SCHED_BYPASS_EN
   // Delayed copy of the issued address; sign plus folded address rebuilds the raw sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TBL_LAT; i++) baddr_q[i] <= '0;
      end else begin
         baddr_q[0] <= tbl_addr_q;
         for (int i = 1; i < TBL_LAT; i++) baddr_q[i] <= baddr_q[i-1];
      end
   end
`endif

   assign tbl_addr = tbl_addr_q;
   assign out_data = out_data_q;
   assign out_stb  = out_stb_q;
   assign ovr      = ovr_q;

endmodule

// File: tb/tb_compressor_sched.sv
// Directed bench for compressor_sched with a scoreboard queue of expected channel outputs.
module tb_compressor_sched;

   localparam int N_CH    = 4;
   localparam int TBL_LAT = 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [N_CH*12-1:0]   in_data;
   logic [N_CH-1:0]      in_stb;
   logic [10:0]          tbl_addr;
   logic [14:0]          tbl_q;
   logic [N_CH*16-1:0]   out_data;
   logic [N_CH-1:0]      out_stb;
   logic [N_CH-1:0]      ovr;
   logic                 ovr_clr;
`ifdef COMPRESSOR_SCHED_BYPASS_EN
   logic [N_CH-1:0]      bypass = '0;
`endif

   compressor_sched #(.N_CH(N_CH), .TBL_LAT(TBL_LAT)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_stb   (in_stb),
`ifdef COMPRESSOR_SCHED_BYPASS_EN
      .bypass   (bypass),
`endif
      .tbl_addr (tbl_addr),
      .tbl_q    (tbl_q),
      .out_data (out_data),
      .out_stb  (out_stb),
      .ovr      (ovr),
      .ovr_clr  (ovr_clr)
   );

   always #5 clk = ~clk;

   // Table model: q = addr<<4, TBL_LAT clocks after the address is sampled.
   logic [14:0] tq_pipe [TBL_LAT];
   always @(posedge clk) begin
      tq_pipe[0] <= {tbl_addr, 4'b0};
      for (int i = 1; i < TBL_LAT; i++) tq_pipe[i] <= tq_pipe[i-1];
   end
   assign tbl_q = tq_pipe[TBL_LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          ch;
      logic [15:0] val;
      int          at;
   } exp_t;

   exp_t sbq[$];
   int   tests = 0;
   int   fails = 0;
   int   k;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // With q = addr<<4 the result is the sample shifted up with sign-filled low nibble.
   task automatic push(input int ch, input logic [11:0] s, input int at);
      exp_t e;
      e.ch  = ch;
      e.val = {s, {4{s[11]}}};
      e.at  = at;
      sbq.push_back(e);
   endtask

   task automatic post(input int ch, input logic [11:0] s);
      in_stb[ch]           = 1'b1;
      in_data[ch*12 +: 12] = s;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (out_stb !== '0) begin
         if (sbq.size() == 0) begin
            check("unexpected_out_stb", 64'(out_stb), 64'd0);
         end else begin
            e = sbq.pop_front();
            check("out_stb", 64'(out_stb), 64'(1) << e.ch);
            check("out_data", 64'(out_data[e.ch*16 +: 16]), 64'(e.val));
            check("out_latency", 64'(cyc), 64'(e.at));
         end
      end
   end

   task automatic single(input int ch, input logic [11:0] s, input logic [10:0] addr,
                         input logic [15:0] val, input string tag);
      k = cyc;
      post(ch, s);
      push(ch, s, k + 4);
      check({tag, "_model"}, 64'(sbq[sbq.size()-1].val), 64'(val));
      @(negedge clk);
      in_stb = '0;
      @(negedge clk);
      check({tag, "_tbl_addr"}, 64'(tbl_addr), 64'(addr));
      repeat (4) @(negedge clk);
      check({tag, "_hold"}, 64'(out_data[ch*16 +: 16]), 64'(val));
   endtask

   initial begin
      reset   = 1'b1;
      in_stb  = '0;
      in_data = '0;
      ovr_clr = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_data", out_data, 64'd0);
      check("rst_tbl_addr", 64'(tbl_addr), 64'd0);
      check("rst_ovr", 64'(ovr), 64'd0);
      check("rst_out_stb", 64'(out_stb), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      single(0, 12'h100, 11'h100, 16'h1000, "ch0_pos");
      single(1, 12'hF00, 11'h0FF, 16'hF00F, "ch1_neg");
      single(1, 12'h800, 11'h7FF, 16'h800F, "ch1_min");

      // Reset with a tag in flight: nothing may emerge and outputs clear.
      post(3, 12'h3C0);
      @(negedge clk);
      in_stb = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_out_data", out_data, 64'd0);
      check("midrst_tbl_addr", 64'(tbl_addr), 64'd0);
      check("midrst_ovr", 64'(ovr), 64'd0);
      check("midrst_out_stb", 64'(out_stb), 64'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      // All channels at once, twice: order 0..3 both times.
      k = cyc;
      post(0, 12'h001); post(1, 12'h7FF); post(2, 12'h800); post(3, 12'hFFF);
      for (int i = 0; i < 4; i++) push(i, in_data[i*12 +: 12], k + 4 + i);
      @(negedge clk);
      in_stb = '0;
      repeat (6) @(negedge clk);
      k = cyc;
      post(0, 12'h555); post(1, 12'hAAA); post(2, 12'h123); post(3, 12'hEDC);
      for (int i = 0; i < 4; i++) push(i, in_data[i*12 +: 12], k + 4 + i);
      @(negedge clk);
      in_stb = '0;
      repeat (6) @(negedge clk);

      // Overrun on ch2 while it waits behind ch0 and ch1.
      k = cyc;
      post(0, 12'h010); post(1, 12'h020); post(2, 12'h123);
      push(0, 12'h010, k + 4);
      push(1, 12'h020, k + 5);
      @(negedge clk);
      in_stb = '0;
      post(2, 12'hA5A);
      push(2, 12'hA5A, k + 6);
      @(negedge clk);
      in_stb = '0;
      check("ovr_set", 64'(ovr), 64'h4);
      repeat (5) @(negedge clk);
      check("ovr_sticky", 64'(ovr), 64'h4);

      // Clear coinciding with a fresh overrun: the overrun wins.
      k = cyc;
      post(2, 12'h111); post(3, 12'h222);
      push(3, 12'h222, k + 4);
      @(negedge clk);
      in_stb  = '0;
      post(2, 12'h333);
      ovr_clr = 1'b1;
      push(2, 12'h333, k + 5);
      @(negedge clk);
      in_stb  = '0;
      ovr_clr = 1'b0;
      check("ovr_clr_collide", 64'(ovr), 64'h4);
      repeat (4) @(negedge clk);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      check("ovr_cleared", 64'(ovr), 64'd0);

      // Strobe on the channel being granted: both samples emerge, no overrun.
      k = cyc;
      post(1, 12'h0AB);
      push(1, 12'h0AB, k + 4);
      @(negedge clk);
      post(1, 12'hBCD);
      push(1, 12'hBCD, k + 5);
      @(negedge clk);
      in_stb = '0;
      check("grant_restrobe_no_ovr", 64'(ovr), 64'd0);
      repeat (6) @(negedge clk);

      check("sb_drained", 64'(sbq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
